reg_file_sb: RTL
================

# reg_file_sb

Parametrised register file with one write port, two read ports, same-cycle write-to-read bypass, an optional hardwired zero register and a per-register pending-write scoreboard. It replaces the per-register bitline array in the CPU datapath. Decode reads two sources and reserves a destination; writeback writes and releases that destination. The scoreboard gives decode the hazard and stall information it would otherwise compute outside the register file.

## Interface
- WIDTH, 16, data width of each register
- DEPTH, 16, number of registers; power of two, at least 2; AW = $clog2(DEPTH)
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and cannot be reserved
- BYPASS, 1, when 1, a same-cycle write is forwarded to the reads and to the busy logic

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- SrcReg1  in  AW  read port 1 address
- SrcReg2  in  AW  read port 2 address
- SrcData1  out  WIDTH  read port 1 data (combinational)
- SrcData2  out  WIDTH  read port 2 data (combinational)
- Busy1  out  1  SrcReg1 has an outstanding write
- Busy2  out  1  SrcReg2 has an outstanding write
- WriteReg  in  1  write enable; also releases the reservation on DstReg
- DstReg  in  AW  write address
- DstData  in  WIDTH  write data
- Reserve  in  1  request to mark ReserveReg pending
- ReserveReg  in  AW  register to reserve
- ReserveStall  out  1  reservation refused this cycle (WAW)
- PendingCount  out  $clog2(DEPTH+1)  number of set pending bits (registered)

## Operation
- State:
  - regs[DEPTH] of WIDTH bits
  - pending[DEPTH] bits
  - PendingCount register
- Reset (rst_n low, asynchronous): all regs = 0, all pending = 0, PendingCount = 0. With combinational outputs this gives SrcData1/2 = 0, Busy1/2 = 0 and ReserveStall = 0 while in reset.
- A register is "zero-locked" when ZERO_REG=1 and its address is 0.
- Write effective (we) = WriteReg and DstReg not zero-locked.
  - On the edge, regs[DstReg] <= DstData.
  - If we and pending[DstReg]=1, the bit clears (release).
  - WriteReg with DstReg zero-locked changes nothing.
- Read port n:
  - SrcRegn zero-locked: SrcDatan = 0.
  - Else BYPASS=1, we, DstReg==SrcRegn: SrcDatan = DstData.
  - Else SrcDatan = regs[SrcRegn].
  - Both ports may address the same register; both return the same value.
- Busy port n:
  - Busyn = pending[SrcRegn] and not (BYPASS=1 and we and DstReg==SrcRegn).
  - A zero-locked source is never busy.
- Reservation:
  - ReserveStall = Reserve and ReserveReg not zero-locked and pending[ReserveReg] and not (we and DstReg==ReserveReg).
  - Reservation taken when Reserve, not zero-locked, not ReserveStall; pending[ReserveReg] <= 1.
  - Reserve of a zero-locked register is ignored with no stall.
- Simultaneous release and reserve of the same register: the reservation wins, the bit stays 1 and there is no stall.
- Release and reserve of different registers in one cycle are both applied.
- PendingCount next value = current count + taken − cleared, where cleared = we and pending[DstReg] was 1. The net change is in {−1, 0, +1}. The count never exceeds DEPTH−ZERO_REG and never wraps.
- Writing a register that is not pending is legal: it updates data and leaves the scoreboard unchanged.

## Timing
- Reads and bypass: zero latency, combinational from SrcReg/DstReg/DstData/WriteReg.
- Write data is visible through the regs array from the cycle after the edge. With BYPASS=1 it is visible in the same cycle. With BYPASS=0 the same-cycle read returns the old value.
- pending bits and PendingCount update on the rising edge. Busy1/2 reflect the new bit the cycle after a reservation.
- ReserveStall is combinational in the same cycle as Reserve. The requester holds Reserve until ReserveStall is low.
- If rst_n asserts mid-cycle, all state clears immediately. A write or reserve on the next edge while rst_n is low is discarded. The first edge after rst_n rises operates normally.

## Test plan
- Reset/zero register:
  - Assert rst_n=0 with WriteReg=1, DstReg=3, DstData=16'hFFFF → SrcData1 (SrcReg1=3) = 0, PendingCount = 0.
  - Release reset, write 16'hFFFF to reg 0 → SrcData1 (SrcReg1=0) = 0, while reg 3 written 16'hFFFF reads 16'hFFFF next cycle.
- Bypass:
  - Same cycle WriteReg=1, DstReg=5, DstData=16'h1234, SrcReg1=SrcReg2=5 → both outputs 16'h1234 in that cycle.
  - With BYPASS=0 the same stimulus returns the old value 0, then 16'h1234 next cycle.
- Scoreboard:
  - Reserve reg 7 → next cycle Busy1 (SrcReg1=7) = 1, PendingCount = 1.
  - Write reg 7 → Busy1 = 0 in that cycle (BYPASS=1), PendingCount = 0 after the edge.
- WAW stall:
  - Reg 4 pending, Reserve reg 4 → ReserveStall = 1, PendingCount stays 1.
  - Same cycle plus WriteReg on reg 4 → ReserveStall = 0, pending[4] remains 1, PendingCount stays 1.
- Concurrency/count:
  - Reserve regs 1..15 on consecutive cycles → PendingCount = 15.
  - Reserve reg 0 → ignored, no stall.
  - Write reg 1 while reserving reg 1 → count unchanged.
  - Write regs 2..15 → count = 1.
- Async reset mid-operation: with 3 registers pending and regs holding nonzero data, pulse rst_n low between edges → immediately PendingCount = 0, Busy = 0, all reads 0.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb
// Register file with one write port, two combinational read ports, optional
// same-cycle write-to-read bypass, optional hardwired zero register and a
// per-register pending-write scoreboard for decode hazard detection.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   SrcReg1/2 -> SrcData1/2    combinational read ports
//   Busy1/2                    source register has an outstanding write
//   WriteReg, DstReg, DstData  write port; a write also releases DstReg
//   Reserve, ReserveReg        mark ReserveReg pending
//   ReserveStall               reservation refused this cycle (WAW)
//   PendingCount               number of pending registers (registered)
module reg_file_sb #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    SrcReg1,
    input  logic [AW-1:0]    SrcReg2,
    output logic [WIDTH-1:0] SrcData1,
    output logic [WIDTH-1:0] SrcData2,
    output logic             Busy1,
    output logic             Busy2,
    input  logic             WriteReg,
    input  logic [AW-1:0]    DstReg,
    input  logic [WIDTH-1:0] DstData,
    input  logic             Reserve,
    input  logic [AW-1:0]    ReserveReg,
    output logic             ReserveStall,
    output logic [CW-1:0]    PendingCount
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;
    logic [CW-1:0]    count_nxt;
    logic             we;
    logic             hit1;
    logic             hit2;
    logic             take;
    logic             clear;

    function automatic logic zlock(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Gating with rst_n keeps bypassed data off the read ports while in reset.
    assign we   = rst_n && WriteReg && !zlock(DstReg);
    assign hit1 = (BYPASS != 0) && we && (DstReg == SrcReg1);
    assign hit2 = (BYPASS != 0) && we && (DstReg == SrcReg2);

    assign SrcData1 = zlock(SrcReg1) ? '0 : (hit1 ? DstData : regs[SrcReg1]);
    assign SrcData2 = zlock(SrcReg2) ? '0 : (hit2 ? DstData : regs[SrcReg2]);

    assign Busy1 = pending[SrcReg1] && !hit1 && !zlock(SrcReg1);
    assign Busy2 = pending[SrcReg2] && !hit2 && !zlock(SrcReg2);

    // A write releasing the same register in this cycle frees it for reservation.
    assign ReserveStall = Reserve && !zlock(ReserveReg) && pending[ReserveReg]
                          && !(we && (DstReg == ReserveReg));

    assign take  = Reserve && !zlock(ReserveReg) && !ReserveStall;
    assign clear = we && pending[DstReg];

    // Reserve is applied after release so a same-register pair leaves the bit set.
    always_comb begin
        pending_nxt = pending;
        if (clear) pending_nxt[DstReg] = 1'b0;
        if (take)  pending_nxt[ReserveReg] = 1'b1;
    end

    always_comb begin
        count_nxt = PendingCount;
        case ({take, clear})
            2'b10:   count_nxt = PendingCount + CW'(1);
            2'b01:   count_nxt = PendingCount - CW'(1);
            default: count_nxt = PendingCount;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pending      <= '0;
            PendingCount <= '0;
        end else begin
            if (we) regs[DstReg] <= DstData;
            pending      <= pending_nxt;
            PendingCount <= count_nxt;
        end
    end

endmodule
